// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_fifo.sv
// Fetch buffer: small power-of-two FIFO of {instr, pc} entries with flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy tracking; flush discards everything.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

  // A push into a full buffer is only legal when a pop frees the slot.
  a_no_push_full : assert property (@(posedge clk) disable iff (!nrst)
    !(push && full && !pop));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding imem
// request at a time, buffers responses and squashes wrong-path fetches.
// Optional FETCH_PERF_EN adds perf_fetched / perf_squashed counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr2,
  output logic [31:0] pc2,
  output logic        valid2
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          kill_q, kill_d;
  logic          push, pop, flush, drop;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_din, fifo_dout;

  // Request and decode-side outputs decode directly from state and buffer flops.
  assign imem_req  = (state_q == REQ) && !fifo_full;
  assign imem_addr = fetch_pc_q;
  assign valid2    = !fifo_empty;
  assign instr2    = fifo_empty ? NOP_INSTR : fifo_dout.instr;
  assign pc2       = fifo_empty ? 32'h0 : fifo_dout.pc;
  assign pop       = valid2 && !stall && !redirect;
  assign fifo_din  = '{instr: imem_rdata, pc: req_pc_q};

  // State, PC and kill registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      kill_q     <= kill_d;
    end
  end

  // Next-state: request/response sequencing, with redirect overriding.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    kill_d     = kill_q;
    push       = 1'b0;
    flush      = 1'b0;
    drop       = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req && imem_gnt) begin
          state_d    = WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
          kill_d  = 1'b0;
          push    = !kill_q && !redirect;
          drop    = kill_q || redirect;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      flush      = 1'b1;
      if (state_q == REQ && imem_req && imem_gnt) kill_d = 1'b1;
      if (state_q == WAIT && !imem_rvalid)        kill_d = 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

`ifdef FETCH_PERF_EN
  // Delivered and squashed instruction counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_fetched  <= 32'h0;
      perf_squashed <= 32'h0;
    end else begin
      perf_fetched  <= perf_fetched + 32'(pop);
      perf_squashed <= perf_squashed + (flush ? 32'(fifo_count) : 32'h0) + 32'(drop);
    end
  end
`else
  logic perf_unused;
  assign perf_unused = ^{fifo_count, drop};
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios push expected
// {pc, instr} pairs; a monitor checks every instruction consumed by decode.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect, stall, valid2;
  logic [31:0] redirect_pc, instr2, pc2;

  // Second instance with RESET_PC at the top of the address space.
  logic        nrst2 = 1'b0;
  logic        m2_req, m2_gnt, m2_rvalid, m2_valid2;
  logic [31:0] m2_addr, m2_rdata, m2_instr2, m2_pc2;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_squashed, m2_perf_fetched, m2_perf_squashed;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb_q[$];

  // Bench memory model state.
  logic        mem_auto = 1'b1;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  int          lat_extra = 0;
  logic [31:0] pend_addr = 32'h0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .nrst(nrst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .instr2(instr2), .pc2(pc2), .valid2(valid2)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .nrst(nrst2),
    .imem_req(m2_req), .imem_addr(m2_addr), .imem_gnt(m2_gnt),
    .imem_rvalid(m2_rvalid), .imem_rdata(m2_rdata),
    .redirect(1'b0), .redirect_pc(32'h0), .stall(1'b0),
    .instr2(m2_instr2), .pc2(m2_pc2), .valid2(m2_valid2)
`ifdef FETCH_PERF_EN
    , .perf_fetched(m2_perf_fetched), .perf_squashed(m2_perf_squashed)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic sb_push(input logic [31:0] pc, input logic [31:0] instr);
    sb_q.push_back({pc, instr});
  endtask

  // Memory: grants whenever idle, answers lat_extra+1 cycles after the grant
  // with data = address + 32'h1357_0000.
  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_auto) begin
        imem_rvalid = 1'b0;
        if (pend) begin
          if (pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr + 32'h1357_0000;
            pend        = 1'b0;
          end else begin
            pend_cnt--;
          end
        end
        imem_gnt = imem_req && !pend;
        if (imem_gnt) begin
          pend      = 1'b1;
          pend_cnt  = lat_extra;
          pend_addr = imem_addr;
        end
      end
    end
  end

  // Monitor: every instruction decode consumes must be the next expected one.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (nrst && valid2 && !stall && !redirect) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL pop_unexpected: got pc2=%h instr2=%h, required no instruction", pc2, instr2);
        end else begin
          e = sb_q.pop_front();
          if ({pc2, instr2} !== e) begin
            n_err++;
            $display("FAIL pop_order: got pc2=%h instr2=%h, required pc2=%h instr2=%h",
                     pc2, instr2, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int t;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    m2_gnt = 1'b0; m2_rvalid = 1'b0; m2_rdata = 32'h0;
    repeat (3) step();

    // Reset values.
    chk("rst_req",    32'(imem_req), 32'd0);
    chk("rst_addr",   imem_addr, 32'h0000_0000);
    chk("rst_valid2", 32'(valid2), 32'd0);
    chk("rst_instr2", instr2, 32'h0000_0013);
    chk("rst_pc2",    pc2, 32'h0);

    // Streaming: addresses 0,4,8,C; one instruction per two cycles.
    sb_push(32'h0, 32'h1357_0000);
    sb_push(32'h4, 32'h1357_0004);
    sb_push(32'h8, 32'h1357_0008);
    sb_push(32'hC, 32'h1357_000C);
    nrst = 1'b1;
    chk("bubble_req", 32'(imem_req), 32'd0);
    step();
    chk("first_req",  32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    step();
    chk("wait_req", 32'(imem_req), 32'd0);
    step();
    chk("first_valid2", 32'(valid2), 32'd1);
    chk("first_pc2",    pc2, 32'h0);
    step(); step();
    chk("second_valid2", 32'(valid2), 32'd1);
    chk("second_pc2",    pc2, 32'h4);

    // Stall with pc 0x8 at the head: outputs hold, buffer fills, request drops.
    t = 0;
    while (!(valid2 && pc2 == 32'h8) && t < 20) begin step(); t++; end
    chk("tmo_pc8", 32'(t < 20), 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_pc2",    pc2, 32'h8);
      chk("stall_instr2", instr2, 32'h1357_0008);
    end
    chk("full_req",   32'(imem_req), 32'd0);
    chk("full_count", 32'(dut.u_fifo.count), 32'd2);

    // Redirect to 0x100 while waiting (no rvalid) on 0x10.
    lat_extra = 1;
    stall = 1'b0;
    t = 0;
    while (!(imem_gnt && imem_addr == 32'h10) && t < 20) begin step(); t++; end
    chk("tmo_gnt10", 32'(t < 20), 32'd1);
    step();
    sb_push(32'h100, 32'h1357_0100);
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0; lat_extra = 0;
    chk("redir1_valid2", 32'(valid2), 32'd0);
    t = 0;
    while (!imem_req && t < 20) begin step(); t++; end
    chk("redir1_addr", imem_addr, 32'h100);

    // Redirect to 0x203 in the same cycle as the grant for 0x108; flush beats pop of 0x104.
    t = 0;
    while (!(imem_gnt && imem_addr == 32'h108) && t < 30) begin step(); t++; end
    chk("tmo_gnt108", 32'(t < 30), 32'd1);
    chk("redir2_pc2", pc2, 32'h104);
    redirect = 1'b1; redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    chk("redir2_valid2", 32'(valid2), 32'd0);
    sb_push(32'h200, 32'h1357_0200);
    sb_push(32'h204, 32'h1357_0204);
    t = 0;
    while (!imem_req && t < 20) begin step(); t++; end
    chk("redir2_addr", imem_addr, 32'h200);
    t = 0;
    while (sb_q.size() != 0 && t < 40) begin step(); t++; end
    chk("tmo_drain1", 32'(t < 40), 32'd1);
    stall = 1'b1;

    // Reset mid-WAIT, then a stray response after release.
    t = 0;
    while (!imem_gnt && t < 20) begin step(); t++; end
    chk("tmo_gnt_rst", 32'(t < 20), 32'd1);
    step();
    mem_auto = 1'b0; pend = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    nrst = 1'b0;
    #1;
    chk("midrst_valid2", 32'(valid2), 32'd0);
    chk("midrst_instr2", instr2, 32'h0000_0013);
    chk("midrst_pc2",    pc2, 32'h0);
    chk("midrst_req",    32'(imem_req), 32'd0);
    chk("midrst_addr",   imem_addr, 32'h0);
    step();
    nrst = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    step();
    imem_rvalid = 1'b0;
    chk("stray_valid2", 32'(valid2), 32'd0);
    chk("stray_req",    32'(imem_req), 32'd1);
    chk("stray_addr",   imem_addr, 32'h0);
    step();
    chk("stray_valid2b", 32'(valid2), 32'd0);
    sb_push(32'h0, 32'h1357_0000);
    mem_auto = 1'b1;
    stall = 1'b0;
    t = 0;
    while (sb_q.size() != 0 && t < 20) begin step(); t++; end
    chk("tmo_drain2", 32'(t < 20), 32'd1);
    stall = 1'b1;

    // PC wrap from FFFF_FFFC to 0.
    chk("wrap_rst_addr", m2_addr, 32'hFFFF_FFFC);
    nrst2 = 1'b1;
    t = 0;
    while (!m2_req && t < 10) begin step(); t++; end
    chk("wrap_addr0", m2_addr, 32'hFFFF_FFFC);
    m2_gnt = 1'b1;
    step();
    m2_gnt = 1'b0; m2_rvalid = 1'b1; m2_rdata = 32'hCAFE_0001;
    step();
    m2_rvalid = 1'b0;
    chk("wrap_pc2",    m2_pc2, 32'hFFFF_FFFC);
    chk("wrap_instr2", m2_instr2, 32'hCAFE_0001);
    chk("wrap_valid2", 32'(m2_valid2), 32'd1);
    chk("wrap_req",    32'(m2_req), 32'd1);
    chk("wrap_addr1",  m2_addr, 32'h0000_0000);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Front-end stage directly upstream of instruction decode.
- Owns the architectural fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake, one request outstanding at a time.
- Buffers returned instructions in a small FIFO and presents them to decode as instr2/pc2/valid2.
- Accepts control-flow redirects from execute and squashes all wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, fetch buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  instruction word.
- redirect  in  1  taken branch/jump from execute.
- redirect_pc  in  32  redirect target.
- stall  in  1  decode cannot accept this cycle.
- instr2  out  32  instruction to decode.
- pc2  out  32  PC of instr2.
- valid2  out  1  instr2/pc2 hold a real instruction.

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC; state = IDLE; FIFO empty; kill = 0.
  - imem_req = 0; imem_addr = RESET_PC.
  - valid2 = 0; instr2 = NOP (32'h0000_0013); pc2 = 0.
- Reset asserted mid-operation: everything returns to the reset values immediately. An in-flight memory response arriving after reset deasserts is ignored, because state is IDLE.
- FSM states IDLE, REQ, WAIT:
  - IDLE: always moves to REQ on the next cycle. This gives one bubble after reset.
  - REQ: imem_req = 1 when FIFO free slots ≥ 1; imem_addr = fetch_pc.
    - On imem_gnt: go to WAIT, latch req_pc = fetch_pc, fetch_pc += 4 (modulo 2^32, wraps from FFFF_FFFC to 0).
  - WAIT: imem_req = 0.
    - On imem_rvalid with kill = 0: push {imem_rdata, req_pc}, go to REQ.
    - On imem_rvalid with kill = 1: drop the response, clear kill, go to REQ.
- Redirect (highest priority, any state):
  - fetch_pc = redirect_pc with bits [1:0] forced to 0, and the FIFO is flushed (count = 0).
  - REQ with no grant: stay in REQ; the next request uses the target.
  - REQ with imem_gnt in the same cycle: go to WAIT with kill = 1. No fetch_pc increment.
  - WAIT without rvalid: stay in WAIT, kill = 1.
  - WAIT with rvalid in the same cycle: drop the response, go to REQ.
  - Redirect and pop in the same cycle: the flush wins.
- Output:
  - valid2 = FIFO not empty; instr2/pc2 = FIFO head. When empty, instr2 = NOP and pc2 = 0.
  - Pop when valid2 && !stall && !redirect.
  - While stall = 1, outputs hold stable.
- FIFO boundaries:
  - Push and pop in the same cycle when full: allowed, count unchanged.
  - Full FIFO: blocks new requests.
  - The FIFO is never pushed while full; assert this in simulation.
- Latency: a response pushed in cycle N is visible on instr2 in cycle N+1. Minimum redirect-to-new-instr2 is 3 cycles with single-cycle memory.

Optional Feature:
- FETCH_PERF_EN: adds outputs perf_fetched (32) and perf_squashed (32).
  - perf_fetched increments on every pop.
  - perf_squashed increments by the number of flushed FIFO entries plus one per killed response.
  - Both reset to 0 and wrap at 2^32.
- Without the macro the ports and counters are absent, with identical functional behaviour.

Decomposition:
- Package fetch_pkg holds:
  - enum fetch_state_e {IDLE, REQ, WAIT};
  - localparam NOP_INSTR = 32'h0000_0013;
  - typedef struct fetch_entry_t {instr[31:0], pc[31:0]}.
- Sub-module fetch_fifo, parameterised by depth:
  - Ports: push, pop, flush, din, dout, empty, full, count.
  - Same clock and asynchronous active-low reset.

Test Plan:
- Reset release with RESET_PC = 0 and imem granting every cycle, rvalid one cycle later → addresses 0, 4, 8…; valid2 first rises with pc2 = 0; instr2 = imem_rdata; throughput one instruction per 2 cycles.
- Hold stall = 1 for 5 cycles → instr2/pc2 unchanged; FIFO fills to 2; imem_req drops; on release, pops resume in order with PCs 0x8 and 0xC.
- Redirect to 0x100 while in WAIT for 0x10 → the 0x10 response is dropped; FIFO empties that cycle; next imem_addr = 0x100; next valid pc2 = 0x100.
- Redirect to 0x203 in the same cycle as imem_gnt → killed response is discarded; imem_addr = 0x200 on the next request.
- Assert nrst low mid-WAIT, then return an rvalid after release → state IDLE, valid2 = 0, instr2 = 0x00000013, and the stray response is ignored.
- RESET_PC = 32'hFFFF_FFFC → second fetch address is 0x0000_0000.
